alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_div.sv | 33 +++
 rtl/alu.sv | 51 +++++
 tb/tb_alu.sv | 118 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: default data width and alu_op encodings.
// Imported by alu and alu_div.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_DIV  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

endpackage

// File: rtl/alu_div.sv
// Unsigned restoring divider, WIDTH combinational stages, zero latency.
// No backpressure: purely combinational, quotient forced to all-ones on divide by zero.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;

  // Each stage shifts in one dividend bit and subtracts the divisor when it fits.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], dividend[i]};
      if (rem >= {1'b0, divisor}) begin
        rem    = rem - {1'b0, divisor};
        quo[i] = 1'b1;
      end
    end
  end

  assign div_by_zero = (divisor == '0);
  assign quotient    = div_by_zero ? '1 : quo;

endmodule

// File: rtl/alu.sv
// Eight-function unsigned ALU; result registered with exactly one cycle latency.
// No backpressure: new operands accepted every cycle, async active-low reset clears the output.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_out
);

  logic [WIDTH-1:0] div_quotient;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;

  alu_div #(.WIDTH(WIDTH)) u_div (
    .dividend    (in1),
    .divisor     (in2),
    .quotient    (div_quotient),
    .div_by_zero (div_by_zero)
  );

  // Default keeps the output defined if alu_op carries X/Z.
  always_comb begin
    alu_out_d = '0;
    case (alu_op)
      ALU_ADD:  alu_out_d = in1 + in2;
      ALU_SUB:  alu_out_d = in1 - in2;
      ALU_MUL:  alu_out_d = in1 * in2;
      ALU_DIV:  alu_out_d = div_by_zero ? '1 : div_quotient;
      ALU_AND:  alu_out_d = in1 & in2;
      ALU_OR:   alu_out_d = in1 | in2;
      ALU_XOR:  alu_out_d = in1 ^ in2;
      ALU_PASS: alu_out_d = in1;
      default:  alu_out_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_out_q <= '0;
    else          alu_out_q <= alu_out_d;
  end

  assign alu_out = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every op, latency and mid-run reset.
module tb_alu;
  import alu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in1     (in1),
    .in2     (in2),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] prev;
    tests_run    = 0;
    tests_failed = 0;

    vecs.push_back('{"add_1_2",      ALU_ADD,  16'd1,     16'd2,     16'd3});
    vecs.push_back('{"add_20_100",   ALU_ADD,  16'd20,    16'd100,   16'd120});
    vecs.push_back('{"add_wrap",     ALU_ADD,  16'hFFFF,  16'd1,     16'h0000});
    vecs.push_back('{"sub_3_3",      ALU_SUB,  16'd3,     16'd3,     16'd0});
    vecs.push_back('{"sub_8_2",      ALU_SUB,  16'd8,     16'd2,     16'd6});
    vecs.push_back('{"sub_2_3",      ALU_SUB,  16'd2,     16'd3,     16'hFFFF});
    vecs.push_back('{"mul_5_6",      ALU_MUL,  16'd5,     16'd6,     16'd30});
    vecs.push_back('{"mul_trunc",    ALU_MUL,  16'h0100,  16'h0100,  16'h0000});
    vecs.push_back('{"mul_partial",  ALU_MUL,  16'h1234,  16'h0010,  16'h2340});
    vecs.push_back('{"div_10_3",     ALU_DIV,  16'd10,    16'd3,     16'd3});
    vecs.push_back('{"div_12_5",     ALU_DIV,  16'd12,    16'd5,     16'd2});
    vecs.push_back('{"div_7_0",      ALU_DIV,  16'd7,     16'd0,     16'hFFFF});
    vecs.push_back('{"div_max_1",    ALU_DIV,  16'hFFFF,  16'd1,     16'hFFFF});
    vecs.push_back('{"div_0_5",      ALU_DIV,  16'd0,     16'd5,     16'd0});
    vecs.push_back('{"div_big",      ALU_DIV,  16'd50000, 16'd7,     16'd7142});
    vecs.push_back('{"and",          ALU_AND,  16'hF0F0,  16'h0FF0,  16'h00F0});
    vecs.push_back('{"or",           ALU_OR,   16'hF0F0,  16'h0FF0,  16'hFFF0});
    vecs.push_back('{"xor",          ALU_XOR,  16'hF0F0,  16'h0FF0,  16'hFF00});
    vecs.push_back('{"pass",         ALU_PASS, 16'hF0F0,  16'h0FF0,  16'hF0F0});

    // Reset held 70 ns with the first vector already on the inputs.
    reset_n = 1'b0;
    alu_op  = vecs[0].op;
    in1     = vecs[0].a;
    in2     = vecs[0].b;
    #30 check("reset_t30", alu_out, 16'h0000);
    #30 check("reset_t60", alu_out, 16'h0000);
    #10 reset_n = 1'b1;
    #3  check("post_release_pre_edge", alu_out, 16'h0000);
    @(posedge clock); #1;
    check(vecs[0].name, alu_out, vecs[0].exp);
    prev = vecs[0].exp;

    for (int i = 1; i < vecs.size(); i++) begin
      @(negedge clock);
      alu_op = vecs[i].op;
      in1    = vecs[i].a;
      in2    = vecs[i].b;
      #1 check({vecs[i].name, "_hold"}, alu_out, prev);
      @(posedge clock); #1;
      check(vecs[i].name, alu_out, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Reset asserted between edges mid-sequence, then resume.
    @(negedge clock);
    alu_op = ALU_ADD; in1 = 16'h0010; in2 = 16'h0020;
    @(posedge clock); #1;
    check("mid_add", alu_out, 16'h0030);
    #2 reset_n = 1'b0;
    #1 check("mid_reset_async", alu_out, 16'h0000);
    @(posedge clock); #1;
    check("mid_reset_held", alu_out, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    alu_op = ALU_XOR; in1 = 16'hAAAA; in2 = 16'h5555;
    #1 check("mid_release_pre_edge", alu_out, 16'h0000);
    @(posedge clock); #1;
    check("mid_resume_xor", alu_out, 16'hFFFF);
    @(negedge clock);
    alu_op = ALU_SUB; in1 = 16'd100; in2 = 16'd1;
    @(posedge clock); #1;
    check("mid_resume_sub", alu_out, 16'd99);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
